// File: rtl/kernel_jacobi_2d_udiv.sv
// -----------------------------------------------------------------------------
// kernel_jacobi_2d_udiv
//
// Iterative unsigned restoring divider: quot = din0 / din1, rem = din0 % din1.
// One quotient bit is produced per ce-qualified clock, MSB first, so a result
// takes din0_WIDTH enabled cycles after the start edge.
//
// Optional feature (compile-time macro KERNEL_JACOBI_2D_UDIV_DBZ_EN):
//   when defined, a start with din1 == 0 completes on the start edge with
//   quot = all ones, rem = 0 and dbz = 1. When undefined, dbz is tied low and
//   a zero divisor runs the normal iteration sequence.
//
// Parameters
//   ID          instance identifier, no functional effect
//   din0_WIDTH  dividend / quotient width
//   din1_WIDTH  divisor / remainder width
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (takes effect regardless of ce)
//   ce     in   clock enable; all state holds while ce = 0
//   start  in   operation request, accepted in IDLE or DONE, ignored in RUN
//   din0   in   unsigned dividend
//   din1   in   unsigned divisor
//   busy   out  high while iterating (state RUN)
//   done   out  high while the result is valid (state DONE)
//   quot   out  quotient, updated on entry to DONE
//   rem    out  remainder, updated on entry to DONE
//   dbz    out  divide-by-zero flag
// -----------------------------------------------------------------------------
module kernel_jacobi_2d_udiv #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd20,
  parameter int unsigned din1_WIDTH = 32'd11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz
);

  localparam int unsigned           CNT_W = $clog2(din0_WIDTH + 1);
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;

  // Datapath: dvd starts as the dividend and is shifted left each iteration;
  // quotient bits enter at the LSB, so after the last iteration it holds the
  // full quotient.
  logic [din0_WIDTH-1:0] dvd;
  logic [din1_WIDTH-1:0] dvs;
  logic [din1_WIDTH:0]   part_rem;

  logic [din1_WIDTH:0]   trial;
  logic [din1_WIDTH:0]   diff;
  logic                  q_bit;
  logic [din1_WIDTH:0]   rem_next;
  logic [din0_WIDTH-1:0] dvd_next;
  logic                  accept;
  logic                  dz_start;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The top bit of part_rem
  // can only be set when the divisor is zero; it then forces a 1 quotient bit
  // exactly as an overflowing compare would.
  assign trial    = {part_rem[din1_WIDTH-1:0], dvd[din0_WIDTH-1]};
  assign diff     = trial - {1'b0, dvs};
  assign q_bit    = part_rem[din1_WIDTH] | (trial >= {1'b0, dvs});
  assign rem_next = q_bit ? diff : trial;
  assign dvd_next = {dvd[din0_WIDTH-2:0], q_bit};

  assign accept   = start && (state != RUN);

`ifdef KERNEL_JACOBI_2D_UDIV_DBZ_EN
  assign dz_start = (din1 == '0);
`else
  assign dz_start = 1'b0;
`endif

  // Control FSM with registered status/result outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else if (ce) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= '0;
            if (dz_start) begin
              // Zero divisor short-circuits straight to a saturated result.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              quot  <= '1;
              rem   <= '0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            quot  <= dvd_next;
            rem   <= rem_next[din1_WIDTH-1:0];
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: operand and partial-remainder registers carry no reset; they are
  // always loaded by an accepted start before their contents are used.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (accept) begin
        dvd      <= din0;
        dvs      <= din1;
        part_rem <= '0;
      end else if (state == RUN) begin
        dvd      <= dvd_next;
        part_rem <= rem_next;
      end
    end
  end

`ifdef KERNEL_JACOBI_2D_UDIV_DBZ_EN
  // Flag follows each accepted start: set for a zero divisor, cleared
  // otherwise, and held across RUN and DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbz <= 1'b0;
    end else if (ce && accept) begin
      dbz <= dz_start;
    end
  end
`else
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_jacobi_2d_udiv.sv
// -----------------------------------------------------------------------------
// tb_kernel_jacobi_2d_udiv
//
// Scoreboard bench for kernel_jacobi_2d_udiv (default widths 20/11). Each
// issued operation pushes its expected quotient, remainder, dbz flag, start
// edge and latency; a monitor pops and compares on every fresh done.
// Honours KERNEL_JACOBI_2D_UDIV_DBZ_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_kernel_jacobi_2d_udiv;

  localparam int W0 = 20;
  localparam int W1 = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          start;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          busy;
  logic          done;
  logic [W0-1:0] quot;
  logic [W1-1:0] rem;
  logic          dbz;

  kernel_jacobi_2d_udiv #(
    .ID         (32'd1),
    .din0_WIDTH (32'd20),
    .din1_WIDTH (32'd11)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .busy  (busy),
    .done  (done),
    .quot  (quot),
    .rem   (rem),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W0-1:0] q;
    logic [W1-1:0] r;
    logic          d;
    int            start_cyc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   edge_ce = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one operation.
  function automatic exp_t model(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                 input int start_cyc, input int extra);
    exp_t e;
    e.start_cyc = start_cyc;
    if (b == '0) begin
      e.q = '1;
`ifdef KERNEL_JACOBI_2D_UDIV_DBZ_EN
      e.r   = '0;
      e.d   = 1'b1;
      e.lat = 0 + extra;
`else
      e.r   = a[W1-1:0];
      e.d   = 1'b0;
      e.lat = W0 + extra;
`endif
    end else begin
      e.q   = a / W0'(b);
      e.r   = W1'(a % W0'(b));
      e.d   = 1'b0;
      e.lat = W0 + extra;
    end
    return e;
  endfunction

  // Edge counter and record of whether the last edge was enabled.
  always @(posedge clk) begin
    cyc++;
    edge_ce = ce;
  end

  // Monitor: a done seen right after an enabled edge is a new completion.
  always @(negedge clk) begin
    if (done && edge_ce && !reset) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quot",    32'(quot),             32'(e.q));
        check("rem",     32'(rem),              32'(e.r));
        check("dbz",     32'(dbz),              32'(e.d));
        check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  // Call at a negedge: presents start for one edge, returns at the next
  // negedge with start released.
  task automatic issue(input logic [W0-1:0] a, input logic [W1-1:0] b,
                       input bit push, input int extra);
    start = 1'b1;
    din0  = a;
    din1  = b;
    if (push) sb.push_back(model(a, b, cyc + 1, extra));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    int            n;

    reset = 1'b1;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem",  32'(rem),  32'd0);
    check("rst_dbz",  32'(dbz),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 100 / 7.
    issue(20'd100, 11'd7, 1'b1, 0);
    check("busy_after_start", 32'(busy), 32'd1);
    drain();

    // Max operands, then back-to-back start held in DONE.
    @(negedge clk);
    issue(20'hFFFFF, 11'h7FF, 1'b1, 0);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 32'(done), 32'd1);
    issue(20'd5, 11'd5, 1'b1, 0);
    check("b2b_busy", 32'(busy), 32'd1);
    drain();

    // ce stall of 5 cycles mid-RUN.
    @(negedge clk);
    issue(20'd100, 11'd7, 1'b1, 5);
    repeat (7) @(negedge clk);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_busy", 32'(busy), 32'd1);
    end
    ce = 1'b1;
    drain();

    // Reset at iteration 10 aborts with no done.
    @(negedge clk);
    issue(20'd100, 11'd7, 1'b0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quot", 32'(quot), 32'd0);
    check("abort_rem",  32'(rem),  32'd0);
    repeat (30) @(negedge clk);
    issue(20'd9, 11'd3, 1'b1, 0);
    drain();

    // Zero divisor, then a nonzero divisor clears dbz.
    @(negedge clk);
    issue(20'd1234, 11'd0, 1'b1, 0);
    drain();
    @(negedge clk);
    issue(20'd100, 11'd7, 1'b1, 0);
    drain();

    // start pulsed at iteration 5 is ignored.
    @(negedge clk);
    issue(20'd100, 11'd7, 1'b1, 0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    din0  = 20'd9;
    din1  = 11'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // A few random operands.
    for (int i = 0; i < 6; i++) begin
      a = 20'($urandom_range(0, 20'hFFFFF));
      b = 11'($urandom_range(1, 11'h7FF));
      @(negedge clk);
      issue(a, b, 1'b1, 0);
      drain();
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
